// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_pkg
//  Description : Shared types and constants for the seven-segment scan
//                controller: scan state enum, dark-display constants and the
//                16-entry hex glyph table (cathodes {g,f,e,d,c,b,a}, active-low).
//  Revision    : 1.0  initial release
// ============================================================================
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    // All cathodes off / all anodes off (both active-low).
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Entry n is the glyph for hex digit n. The concatenation lists entry 15
    // first so that GLYPH_TABLE[n] indexes naturally.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage : seg_scan_pkg
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg
//  Description : Combinational 4-bit hex nibble to seven-segment decoder.
//  Ports       : i_nibble [3:0]  hex value to display
//                o_seg    [6:0]  cathodes {g,f,e,d,c,b,a}, active-low
//  Revision    : 1.0  initial release
// ============================================================================
module hex_to_seg
    import seg_scan_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = GLYPH_TABLE[i_nibble];

endmodule : hex_to_seg
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Scan controller for a 4-digit multiplexed seven-segment
//                display. Each digit is driven for TICK_DIV cycles followed by
//                BLANK_CYCLES of all-anodes-off dead time. New values arrive
//                through a valid/ready handshake into a shadow buffer and are
//                swapped into the active buffer only at frame boundaries, so a
//                frame never tears. Optional leading-zero blanking.
//  Ports       : clk, rst (sync, active-low)
//                en                       scan enable, 0 = dark
//                load_valid/load_ready    shadow buffer handshake
//                load_data[15:0]          four nibbles, [3:0] = digit 0
//                load_dp[3:0]             decimal points, 1 = lit
//                lz_blank                 blank leading zero digits
//                annode[3:0]              anodes, active-low
//                seg[6:0]                 cathodes {g..a}, active-low
//                dp                       decimal point cathode, active-low
//                frame_done               1-cycle pulse per completed frame
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int NUM_DIGITS   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    input  logic        lz_blank,
    output logic [3:0]  annode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int c_CNT_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_DRIVE_LAST = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYCLES - 1);
    localparam logic [1:0]         c_LAST_DIGIT = 2'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // State and buffers
    // ------------------------------------------------------------------
    scan_state_t        r_state;
    logic [1:0]         r_digit;
    logic [c_CNT_W-1:0] r_cnt;

    logic [15:0]        r_active;
    logic [3:0]         r_active_dp;
    logic [15:0]        r_shadow;
    logic [3:0]         r_shadow_dp;
    logic               r_shadow_full;

    logic [3:0]         r_annode;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic               r_frame_done;

    // ------------------------------------------------------------------
    // Next-state view. Outputs are registered from these next values so
    // that the pins change on the same edge as the state register.
    // ------------------------------------------------------------------
    scan_state_t        w_state_nxt;
    logic [1:0]         w_digit_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_frame_end;
    logic               w_swap;
    logic               w_accept;
    logic [15:0]        w_active_nxt;
    logic [3:0]         w_active_dp_nxt;
    logic [3:0]         w_sel_nibble;
    logic [6:0]         w_glyph;
    logic               w_lz_hit;

    always_comb begin
        w_state_nxt = r_state;
        w_digit_nxt = r_digit;
        w_cnt_nxt   = r_cnt;
        w_frame_end = 1'b0;

        if (!en) begin
            w_state_nxt = IDLE;
            w_digit_nxt = 2'd0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = DRIVE;
                    w_digit_nxt = 2'd0;
                    w_cnt_nxt   = '0;
                end
                DRIVE: begin
                    if (r_cnt == c_DRIVE_LAST) begin
                        w_state_nxt = BLANK;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (r_cnt == c_BLANK_LAST) begin
                        w_state_nxt = DRIVE;
                        w_cnt_nxt   = '0;
                        if (r_digit == c_LAST_DIGIT) begin
                            w_digit_nxt = 2'd0;
                            w_frame_end = 1'b1;
                        end else begin
                            w_digit_nxt = r_digit + 2'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_digit_nxt = 2'd0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // The swap only happens with a full shadow, and ready is low while full,
    // so a swap and an accept can never coincide.
    assign w_swap          = w_frame_end && r_shadow_full;
    assign w_accept        = load_valid && !r_shadow_full;
    assign w_active_nxt    = w_swap ? r_shadow    : r_active;
    assign w_active_dp_nxt = w_swap ? r_shadow_dp : r_active_dp;

    // Decode the nibble of the digit about to be driven, taken from the value
    // that will be active after this edge (covers the swap edge correctly).
    assign w_sel_nibble = w_active_nxt[{w_digit_nxt, 2'b00} +: 4];

    // Leading zero: this digit and every more-significant nibble are zero.
    assign w_lz_hit = lz_blank && (w_digit_nxt != 2'd0)
                      && ((w_active_nxt >> {w_digit_nxt, 2'b00}) == 16'h0000);

    hex_to_seg u_hex_to_seg (
        .i_nibble (w_sel_nibble),
        .o_seg    (w_glyph)
    );

    // ------------------------------------------------------------------
    // Scan FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_digit      <= 2'd0;
            r_cnt        <= '0;
            r_annode     <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_digit      <= w_digit_nxt;
            r_cnt        <= w_cnt_nxt;
            r_frame_done <= w_frame_end;
            if (w_state_nxt == DRIVE) begin
                r_annode <= ~(4'b0001 << w_digit_nxt);
                r_seg    <= w_lz_hit ? SEG_OFF : w_glyph;
                r_dp     <= w_lz_hit | ~w_active_dp_nxt[w_digit_nxt];
            end else begin
                r_annode <= AN_OFF;
                r_seg    <= SEG_OFF;
                r_dp     <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow / active double buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_active      <= 16'h0000;
            r_active_dp   <= 4'h0;
            r_shadow      <= 16'h0000;
            r_shadow_dp   <= 4'h0;
            r_shadow_full <= 1'b0;
        end else begin
            r_active    <= w_active_nxt;
            r_active_dp <= w_active_dp_nxt;
            if (w_accept) begin
                r_shadow      <= load_data;
                r_shadow_dp   <= load_dp;
                r_shadow_full <= 1'b1;
            end else if (w_swap) begin
                r_shadow_full <= 1'b0;
            end
        end
    end

    assign load_ready = ~r_shadow_full;
    assign annode     = r_annode;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule : seg_scan_ctrl
`default_nettype wire
